// File: rtl/acq_fifo_packed.sv
// acq_fifo_packed: I2C target acquisition FIFO storing events as (DataWidth+1)-bit words.
// Optional watermark pulse output is enabled by defining ACQ_FIFO_WATERMARK_EN.
module acq_fifo_packed #(
  parameter int unsigned           Depth      = 64,
  parameter int unsigned           DataWidth  = 8,
  parameter int unsigned           IdWidth    = 3,
  parameter logic [2**IdWidth-1:0] DataIdMask = 8'b0001_1010,
  parameter int unsigned           LvlWidth   = $clog2(Depth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 fifo_clr_i,
  input  logic                 acq_valid_i,
  output logic                 acq_ready_o,
  input  logic [IdWidth-1:0]   acq_id_i,
  input  logic [DataWidth-1:0] acq_data_i,
  output logic                 rd_valid_o,
  input  logic                 rd_ready_i,
  output logic [IdWidth-1:0]   rd_id_o,
  output logic [DataWidth-1:0] rd_data_o,
  output logic [LvlWidth-1:0]  acq_lvl_o,
  output logic                 acq_full_o,
  input  logic [LvlWidth-1:0]  thresh_i,
  output logic                 thresh_o
);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready. Valid never
  // depends on ready; acq_ready_o may depend on acq_id_i and on a same-cycle pop.

  localparam int unsigned          WordWidth = DataWidth + 1;
  localparam int unsigned          PtrWidth  = $clog2(Depth);
  localparam logic [LvlWidth-1:0]  LvlDepth  = LvlWidth'(Depth);

  typedef enum logic {
    StIdle     = 1'b0,
    StEmitData = 1'b1
  } state_e;

  state_e               state_q;
  logic [PtrWidth-1:0]  wr_ptr_q;
  logic [PtrWidth-1:0]  rd_ptr_q;
  logic [LvlWidth-1:0]  lvl_q;
  logic [DataWidth-1:0] pend_data_q;
  logic [WordWidth-1:0] mem_q [Depth];

  // Pointer advance modulo Depth; Depth need not be a power of two.
  function automatic logic [PtrWidth-1:0] ptr_adv(input logic [PtrWidth-1:0] ptr,
                                                  input logic [1:0]          inc);
    logic [PtrWidth:0] sum;
    sum = {1'b0, ptr} + (PtrWidth+1)'(inc);
    if (sum >= (PtrWidth+1)'(Depth)) begin
      sum = sum - (PtrWidth+1)'(Depth);
    end
    return sum[PtrWidth-1:0];
  endfunction

  function automatic logic id_two_word(input logic [IdWidth-1:0] id);
    return (id != '0) && DataIdMask[id];
  endfunction

  // ---------------------------------------------------------------- pop side
  logic [WordWidth-1:0] head_word;
  logic [WordWidth-1:0] next_word;
  logic [IdWidth-1:0]   head_id;
  logic                 head_ctrl;
  logic                 head_two;
  logic [1:0]           pop_cnt;
  logic                 unused_next_msb;

  assign head_word       = mem_q[rd_ptr_q];
  assign next_word       = mem_q[ptr_adv(rd_ptr_q, 2'd1)];
  assign head_ctrl       = head_word[DataWidth];
  assign head_id         = head_word[IdWidth-1:0];
  assign head_two        = head_ctrl && id_two_word(head_id);
  assign unused_next_msb = next_word[DataWidth];

  // A two-word event stays hidden until its data word has landed (lvl >= 2).
  always_comb begin
    rd_valid_o = 1'b0;
    rd_id_o    = '0;
    rd_data_o  = '0;
    if (head_two) begin
      if (lvl_q >= LvlWidth'(2)) begin
        rd_valid_o = 1'b1;
        rd_id_o    = head_id;
        rd_data_o  = next_word[DataWidth-1:0];
      end
    end else if (lvl_q != '0) begin
      rd_valid_o = 1'b1;
      if (head_ctrl) begin
        rd_id_o = head_id;
      end else begin
        rd_data_o = head_word[DataWidth-1:0];
      end
    end
  end

  always_comb begin
    pop_cnt = 2'd0;
    if (rd_valid_o && rd_ready_i) begin
      pop_cnt = head_two ? 2'd2 : 2'd1;
    end
  end

  // --------------------------------------------------------------- push side
  logic [LvlWidth:0]    free_words;
  logic                 need_two;
  logic                 acq_accept;
  logic                 wr_en;
  logic [WordWidth-1:0] wr_word;

  // Words freed by a same-cycle pop count as space, so a full FIFO can still accept.
  assign free_words  = {1'b0, LvlDepth} - {1'b0, lvl_q} + (LvlWidth+1)'(pop_cnt);
  assign need_two    = id_two_word(acq_id_i);
  assign acq_ready_o = rst_ni && !fifo_clr_i && (state_q == StIdle) &&
                       (need_two ? (free_words >= (LvlWidth+1)'(2)) : (free_words != '0));
  assign acq_accept  = acq_valid_i && acq_ready_o;
  assign wr_en       = acq_accept || ((state_q == StEmitData) && !fifo_clr_i);

  always_comb begin
    wr_word = {1'b0, acq_data_i};
    if (state_q == StEmitData) begin
      wr_word = {1'b0, pend_data_q};
    end else if (acq_id_i != '0) begin
      wr_word = {1'b1, DataWidth'(acq_id_i)};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      lvl_q       <= '0;
      pend_data_q <= '0;
    end else if (fifo_clr_i) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      lvl_q       <= '0;
      pend_data_q <= '0;
    end else begin
      wr_ptr_q <= ptr_adv(wr_ptr_q, {1'b0, wr_en});
      rd_ptr_q <= ptr_adv(rd_ptr_q, pop_cnt);
      lvl_q    <= lvl_q + LvlWidth'(wr_en) - LvlWidth'(pop_cnt);
      case (state_q)
        StIdle: begin
          if (acq_accept && need_two) begin
            state_q     <= StEmitData;
            pend_data_q <= acq_data_i;
          end
        end
        StEmitData: state_q <= StIdle;
        default:    state_q <= StIdle;
      endcase
    end
  end

  // Storage carries no reset; the pop side only looks at words covered by lvl.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_word;
    end
  end

  assign acq_lvl_o  = lvl_q;
  assign acq_full_o = (lvl_q == LvlDepth);

  // --------------------------------------------------------------- watermark
`ifdef ACQ_FIFO_WATERMARK_EN
  logic [LvlWidth-1:0] lvl_prev_q;
  logic                thresh_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lvl_prev_q <= '0;
      thresh_q   <= 1'b0;
    end else if (fifo_clr_i) begin
      lvl_prev_q <= '0;
      thresh_q   <= 1'b0;
    end else begin
      lvl_prev_q <= lvl_q;
      thresh_q   <= (thresh_i != '0) && (lvl_q >= thresh_i) && (lvl_prev_q < thresh_i);
    end
  end

  assign thresh_o = thresh_q;
`else
  logic unused_thresh;
  assign unused_thresh = ^thresh_i;
  assign thresh_o      = 1'b0;
`endif

  // Two words are reserved at accept, so the data word always has room.
  lvl_bound_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    lvl_q <= LvlDepth);
  emit_space_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == StEmitData) |-> (lvl_q < LvlDepth));

endmodule

// File: tb/tb_acq_fifo_packed.sv
// Bench for acq_fifo_packed: directed vector table, corner sequences and randomized
// traffic against an event-queue reference model.
module tb_acq_fifo_packed;

  localparam int         DEPTH = 64;
  localparam int         DW    = 8;
  localparam int         IW    = 3;
  localparam int         LW    = 7;
  localparam logic [7:0] MASK  = 8'b0001_1010;

  logic          clk;
  logic          rst_n;
  logic          fifo_clr;
  logic          acq_valid;
  logic          acq_ready;
  logic [IW-1:0] acq_id;
  logic [DW-1:0] acq_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [IW-1:0] rd_id;
  logic [DW-1:0] rd_data;
  logic [LW-1:0] acq_lvl;
  logic          acq_full;
  logic [LW-1:0] thresh_in;
  logic          thresh_out;

  acq_fifo_packed #(
    .Depth      (DEPTH),
    .DataWidth  (DW),
    .IdWidth    (IW),
    .DataIdMask (MASK),
    .LvlWidth   (LW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .fifo_clr_i  (fifo_clr),
    .acq_valid_i (acq_valid),
    .acq_ready_o (acq_ready),
    .acq_id_i    (acq_id),
    .acq_data_i  (acq_data),
    .rd_valid_o  (rd_valid),
    .rd_ready_i  (rd_ready),
    .rd_id_o     (rd_id),
    .rd_data_o   (rd_data),
    .acq_lvl_o   (acq_lvl),
    .acq_full_o  (acq_full),
    .thresh_i    (thresh_in),
    .thresh_o    (thresh_out)
  );

  // ------------------------------------------------------------ clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------ reference model
  logic [IW+DW-1:0] exp_q[$];   // queued events as {id, data}
  int               m_lvl;
  bit               m_emit;     // tail event still owes its data word
  int               m_lvl_prev;
  bit               m_thr;

  int checks;
  int failures;

  logic          s_ready, s_valid, s_full, s_thr;
  logic [IW-1:0] s_id;
  logic [DW-1:0] s_data;
  logic [LW-1:0] s_lvl;

  function automatic bit two_word(input logic [IW-1:0] id);
    return (id != 0) && MASK[id];
  endfunction

  task automatic m_reset();
    exp_q.delete();
    m_lvl      = 0;
    m_emit     = 1'b0;
    m_lvl_prev = 0;
    m_thr      = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check against the model, advance the model at posedge.
  task automatic cycle(input logic v, input logic [IW-1:0] id, input logic [DW-1:0] d,
                       input logic rdy, input logic clr);
    logic          e_valid, e_ready, e_pop;
    logic [IW-1:0] e_id;
    logic [DW-1:0] e_data;
    logic [IW+DW-1:0] dummy;
    int            words, need, free_w, thr;
    @(negedge clk);
    acq_valid = v;
    acq_id    = id;
    acq_data  = d;
    rd_ready  = rdy;
    fifo_clr  = clr;
    #1;
    e_valid = 1'b0;
    e_id    = '0;
    e_data  = '0;
    words   = 0;
    if (exp_q.size() > 0) begin
      words   = two_word(exp_q[0][IW+DW-1:DW]) ? 2 : 1;
      e_valid = (m_lvl >= words);
    end
    if (e_valid) begin
      e_id   = exp_q[0][IW+DW-1:DW];
      e_data = exp_q[0][DW-1:0];
    end
    e_pop   = e_valid && rdy;
    need    = two_word(id) ? 2 : 1;
    free_w  = DEPTH - m_lvl + (e_pop ? words : 0);
    e_ready = !clr && !m_emit && (free_w >= need);

    s_ready = acq_ready;
    s_valid = rd_valid;
    s_id    = rd_id;
    s_data  = rd_data;
    s_lvl   = acq_lvl;
    s_full  = acq_full;
    s_thr   = thresh_out;
    chk("acq_ready", s_ready, e_ready);
    chk("rd_valid", s_valid, e_valid);
    chk("rd_id", s_id, e_id);
    chk("rd_data", s_data, e_data);
    chk("acq_lvl", s_lvl, m_lvl);
    chk("acq_full", s_full, m_lvl == DEPTH);
    chk("thresh_o", s_thr, m_thr);

    @(posedge clk);
    thr = int'(thresh_in);
    if (clr) begin
      m_reset();
    end else begin
`ifdef ACQ_FIFO_WATERMARK_EN
      m_thr      = (thr != 0) && (m_lvl >= thr) && (m_lvl_prev < thr);
      m_lvl_prev = m_lvl;
`else
      thr = 0;
`endif
      if (e_pop) begin
        dummy = exp_q.pop_front();
        m_lvl -= words;
      end
      if (m_emit) begin
        m_lvl += 1;
        m_emit = 1'b0;
      end else if (v && e_ready) begin
        exp_q.push_back({id, (id == 0 || two_word(id)) ? d : 8'h00});
        m_lvl += 1;
        if (two_word(id)) m_emit = 1'b1;
      end
    end
  endtask

  // ------------------------------------------------------- directed table
  typedef struct packed {
    logic          v;
    logic [IW-1:0] id;
    logic [DW-1:0] d;
    logic          rdy;
    logic          clr;
    logic          e_ready;
    logic          e_valid;
    logic [IW-1:0] e_id;
    logic [DW-1:0] e_data;
    logic [LW-1:0] e_lvl;
  } vec_t;

  vec_t vecs[15];
  int   pulses;
  int   exp_pulses;

  initial begin
    checks   = 0;
    failures = 0;
    m_reset();

    //            v     id    data   rdy   clr  | ready valid id    data   lvl
    vecs[0]  = '{1'b1, 3'd0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 7'd0};
    vecs[1]  = '{1'b1, 3'd2, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 8'hA5, 7'd1};
    vecs[2]  = '{1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 8'hA5, 7'd2};
    vecs[3]  = '{1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 8'h00, 7'd1};
    vecs[4]  = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 7'd0};
    vecs[5]  = '{1'b1, 3'd1, 8'h84, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 7'd0};
    vecs[6]  = '{1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 7'd1};
    vecs[7]  = '{1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 8'h84, 7'd2};
    vecs[8]  = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 7'd0};
    vecs[9]  = '{1'b1, 3'd3, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 7'd0};
    vecs[10] = '{1'b1, 3'd0, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 7'd1};
    vecs[11] = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 7'd0};
    vecs[12] = '{1'b1, 3'd0, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 7'd0};
    vecs[13] = '{1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 8'h22, 7'd1};
    vecs[14] = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 7'd0};

    // Reset: outputs quiet even with a push offered.
    rst_n     = 1'b1;
    acq_valid = 1'b1;
    acq_id    = '0;
    acq_data  = 8'hFF;
    rd_ready  = 1'b1;
    fifo_clr  = 1'b0;
    thresh_in = 7'd4;
    #1 rst_n  = 1'b0;
    #11;
    chk("rst acq_ready", acq_ready, 0);
    chk("rst rd_valid", rd_valid, 0);
    chk("rst rd_id", rd_id, 0);
    chk("rst rd_data", rd_data, 0);
    chk("rst acq_lvl", acq_lvl, 0);
    chk("rst acq_full", acq_full, 0);
    chk("rst thresh_o", thresh_out, 0);
    acq_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      cycle(vecs[i].v, vecs[i].id, vecs[i].d, vecs[i].rdy, vecs[i].clr);
      chk($sformatf("vec%0d ready", i), s_ready, vecs[i].e_ready);
      chk($sformatf("vec%0d valid", i), s_valid, vecs[i].e_valid);
      chk($sformatf("vec%0d id", i), s_id, vecs[i].e_id);
      chk($sformatf("vec%0d data", i), s_data, vecs[i].e_data);
      chk($sformatf("vec%0d lvl", i), s_lvl, vecs[i].e_lvl);
    end

    // Fill to Depth-1: a two-word id is refused, a data word still fits.
    cycle(1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH - 1; i++) cycle(1'b1, 3'd0, 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 3'd4, 8'h55, 1'b0, 1'b0);
    chk("nack refused at depth-1", s_ready, 0);
    chk("lvl at depth-1", s_lvl, DEPTH - 1);
    cycle(1'b1, 3'd0, 8'hEE, 1'b0, 1'b0);
    chk("id0 accepted at depth-1", s_ready, 1);
    cycle(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    chk("full flag", s_full, 1);
    chk("lvl full", s_lvl, DEPTH);

    // Full with a two-word head: pop 2 and push 1 in the same cycle.
    cycle(1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
    cycle(1'b1, 3'd1, 8'h3C, 1'b0, 1'b0);
    for (int i = 0; i < 100 && m_lvl < DEPTH; i++) cycle(1'b1, 3'd0, 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 3'd0, 8'h77, 1'b1, 1'b0);
    chk("full before pop+push", s_full, 1);
    chk("ready when full with pop", s_ready, 1);
    chk("head id start", s_id, 1);
    chk("head data start", s_data, 8'h3C);
    cycle(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    chk("lvl after pop2 push1", s_lvl, DEPTH - 1);
    for (int i = 0; i < 5 * DEPTH; i++)
      cycle(1'b1, 3'($urandom_range(0, 7)), 8'($urandom), (i % 2) == 0, 1'b0);

    // Reset in the middle of EmitData.
    cycle(1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
    cycle(1'b1, 3'd3, 8'h99, 1'b0, 1'b0);
    @(negedge clk);
    acq_valid = 1'b0;
    rd_ready  = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("midemit rst lvl", acq_lvl, 0);
    chk("midemit rst valid", rd_valid, 0);
    chk("midemit rst ready", acq_ready, 0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    chk("post rst lvl", s_lvl, 0);
    chk("post rst valid", s_valid, 0);
    chk("post rst ready", s_ready, 1);

    // Watermark at 4: one pulse on the way up, none while the level holds.
    cycle(1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
    thresh_in = 7'd4;
    pulses    = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(i < 4, 3'd0, 8'(8'h40 + i), 1'b0, 1'b0);
      if (s_thr) pulses++;
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 3'd0, 8'(8'h50 + i), 1'b1, 1'b0);
      if (s_thr) pulses++;
    end
`ifdef ACQ_FIFO_WATERMARK_EN
    exp_pulses = 1;
`else
    exp_pulses = 0;
`endif
    chk("thresh pulse count", pulses, exp_pulses);

    // Randomized traffic with varying drain pressure, rare clears, moving watermark.
    for (int i = 0; i < 3000; i++) begin
      if ((i % 256) == 0) thresh_in = 7'($urandom_range(0, 10));
      cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 8'($urandom),
            $urandom_range(0, 9) < (((i / 500) % 2) == 1 ? 3 : 8),
            $urandom_range(0, 299) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/acq_fifo_packed.md
Name: acq_fifo_packed

Overview:
- Next-generation I2C target acquisition FIFO.
- Stores ACQ events in a compact (DataWidth+1)-bit word format instead of the fixed 3-bit-id + 8-bit-data format:
  - word MSB = 1: control word, carrying the event id.
  - word MSB = 0: data word.
- Ids that carry a byte (e.g. Start/Restart address, Nack data) are stored as a control word followed by a data word.
- Sits between the target FSM (push side) and the CSR/software read path (pop side). Depth, data width, id width and data-carrying id set are all parametrised.

Parameters:
- Depth, 64: FIFO capacity in words; ≥4.
- DataWidth, 8: data byte width.
- IdWidth, 3: event id width; must be ≤ DataWidth.
- DataIdMask, 8'b0001_1010: bit n set ⇒ id n is stored as control+data (two words). Default marks Start(1), Restart(3), Nack(4). Width is 2**IdWidth. Bit 0 is ignored (id 0 = plain data).
- LvlWidth, $clog2(Depth+1): width of the level output.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- fifo_clr_i  in  1  synchronous clear (flush contents and FSM)
- acq_valid_i  in  1  push request
- acq_ready_o  out  1  push accept
- acq_id_i  in  IdWidth  event id
- acq_data_i  in  DataWidth  event data
- rd_valid_o  out  1  complete event available at head
- rd_ready_i  in  1  pop request
- rd_id_o  out  IdWidth  head event id
- rd_data_o  out  DataWidth  head event data (0 for data-less control events)
- acq_lvl_o  out  LvlWidth  occupied words
- acq_full_o  out  1  lvl == Depth
- thresh_i  in  LvlWidth  watermark level (feature only)
- thresh_o  out  1  watermark pulse (feature only)

Behaviour:
- Reset (async, rst_ni=0):
  - lvl = 0, pointers = 0, FSM = Idle.
  - Outputs: acq_ready_o=0, rd_valid_o=0, rd_id_o=0, rd_data_o=0, acq_lvl_o=0, acq_full_o=0, thresh_o=0.
  - First cycle after reset release: acq_ready_o may be 1.
- Push-side FSM, two states:
  - Idle:
    - acq_ready_o = free ≥ 1 for id 0 or any id with mask bit clear; free ≥ 2 for ids with mask bit set.
    - Accept on valid & ready.
    - id==0: write {0,data}.
    - Id with mask clear: write {1, zero-extended id}.
    - Id with mask set: write {1,id}, latch data, go to EmitData.
  - EmitData:
    - acq_ready_o = 0.
    - Write {0, latched data}; return to Idle.
    - Space is always available here, because 2 words were reserved at accept.
- Pop side (combinational on head word and head+1):
  - Head MSB=0: event = (id 0, data). Valid if lvl ≥ 1.
  - Head MSB=1 with mask bit set: event = (id, data of next word). Valid only if lvl ≥ 2; this hides the half-written event during EmitData.
  - Head MSB=1 with mask bit clear: event = (id, 0). Valid if lvl ≥ 1.
  - When not valid, rd_id_o and rd_data_o are 0.
  - Pop on rd_valid_o & rd_ready_i: advance read pointer by 1 or 2 words.
- Timing:
  - A pushed word is visible at the pop side the cycle after its write; no fall-through.
  - Two-word event: rd_valid_o can rise 2 cycles after accept at the earliest.
- Level and pointers:
  - lvl updates every cycle as lvl + written − popped, with written ∈ {0,1} and popped ∈ {0,1,2}.
  - Simultaneous push and pop is allowed, including when full: a pop of 2 with a push of 1 leaves lvl − 1.
  - Pointers wrap modulo Depth; Depth need not be a power of 2.
- fifo_clr_i:
  - Next cycle: lvl = 0, pointers = 0, FSM = Idle.
  - A pending EmitData word is discarded.
  - A push offered in the clear cycle is dropped; acq_ready_o=0 during clear.
- Reset mid-EmitData: same result as clear.

Optional Feature:
- Macro: ACQ_FIFO_WATERMARK_EN.
- With the macro defined:
  - thresh_o is a registered one-cycle pulse when lvl crosses from < thresh_i to ≥ thresh_i.
  - thresh_i = 0 disables it (no pulse).
- Without the macro:
  - thresh_o is tied 0.
  - thresh_i is unused.
  - No watermark logic is generated.

Test Plan:
- Push id0 data 0xA5, then id2 (Stop):
  - lvl goes 1 then 2.
  - Pops return (0,0xA5) then (2,0x00).
  - lvl returns to 0.
- Push id1 (Start) with data 0x84:
  - acq_ready_o=0 in the next cycle.
  - rd_valid_o stays 0 until lvl=2.
  - Pop returns (1,0x84); lvl 2→0 in one pop.
- Fill with data words to lvl=Depth−1, offer id4 (Nack):
  - acq_ready_o=0 because only 1 word is free.
  - Offer id0: accepted; acq_full_o=1.
- Full FIFO with head two-word event; pop and push id0 in the same cycle:
  - lvl = Depth−1.
  - Read pointer wraps correctly over 3 full cycles.
- Assert fifo_clr_i during EmitData of id3:
  - lvl=0 next cycle; rd_valid_o=0.
  - Subsequent id0 push/pop works.
- With ACQ_FIFO_WATERMARK_EN and thresh_i=4:
  - Push 4 data words: thresh_o pulses exactly once, on the cycle after lvl reaches 4.
  - Pop 1 and push 1: no second pulse.
  - Without the macro, thresh_o stays 0.
